// File: rtl/dot_seq_pkg.sv
// ============================================================================
// dot_seq_pkg : shared types and constants for the dot-product MAC sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package dot_seq_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 18;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN1 = 3'd2,
    DRAIN2 = 3'd3,
    HOLD   = 3'd4
  } state_t;

  // Shadow sum must absorb up to 2^len_w-1 products without wrapping.
  function automatic int shadow_w(input int acc_w, input int len_w);
    return acc_w + len_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_seq_feeder_if.sv
// ============================================================================
// dot_seq_feeder_if : command, operand stream, MAC and result signals
// Optional res_ovf present when DOT_SEQ_OVF_EN is defined. Rev 1.0
// ============================================================================
`default_nettype none

interface dot_seq_feeder_if #(
  parameter int LEN_W = 8,
  parameter int OP_W  = dot_seq_pkg::OP_W,
  parameter int ACC_W = dot_seq_pkg::ACC_W
);
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_a;
  logic [OP_W-1:0]  in_b;
  logic [OP_W-1:0]  mac_dataa;
  logic [OP_W-1:0]  mac_datab;
  logic             mac_clken;
  logic             mac_sload;
  logic [ACC_W-1:0] mac_result;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;

`ifdef DOT_SEQ_OVF_EN
  logic             res_ovf;

  modport slave (
    input  start, vec_len, in_valid, in_a, in_b, mac_result, res_ready,
    output busy, in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data, res_ovf
  );
  modport master (
    output start, vec_len, in_valid, in_a, in_b, mac_result, res_ready,
    input  busy, in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data, res_ovf
  );
`else
  modport slave (
    input  start, vec_len, in_valid, in_a, in_b, mac_result, res_ready,
    output busy, in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data
  );
  modport master (
    output start, vec_len, in_valid, in_a, in_b, mac_result, res_ready,
    input  busy, in_ready, mac_dataa, mac_datab, mac_clken, mac_sload,
           res_valid, res_data
  );
`endif

endinterface

`default_nettype wire

// File: rtl/dot_seq_opreg.sv
// ============================================================================
// dot_seq_opreg : registered operand / clken / sload stage feeding the MAC
// Rev 1.0
// ============================================================================
`default_nettype none

module dot_seq_opreg #(
  parameter int OP_W = dot_seq_pkg::OP_W
) (
  input  logic            clk,
  input  logic            aclr,
  input  logic            i_beat,
  input  logic            i_last,
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_b,
  output logic [OP_W-1:0] o_dataa,
  output logic [OP_W-1:0] o_datab,
  output logic            o_clken,
  output logic            o_sload
);

  logic [OP_W-1:0] r_dataa;
  logic [OP_W-1:0] r_datab;
  logic            r_clken;
  logic            r_sload;

  // Data registers hold across bubbles; only clken/sload drop.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_dataa <= '0;
      r_datab <= '0;
      r_clken <= 1'b0;
      r_sload <= 1'b0;
    end else begin
      r_clken <= i_beat;
      r_sload <= i_beat & i_last;
      if (i_beat) begin
        r_dataa <= i_a;
        r_datab <= i_b;
      end
    end
  end

  assign o_dataa = r_dataa;
  assign o_datab = r_datab;
  assign o_clken = r_clken;
  assign o_sload = r_sload;

endmodule

`default_nettype wire

// File: rtl/dot_seq_feeder.sv
// ============================================================================
// dot_seq_feeder : sequences operand pairs into a signed MAC, returns the sum
// Optional overflow flag via DOT_SEQ_OVF_EN. Rev 1.0
// ============================================================================
`default_nettype none

module dot_seq_feeder #(
  parameter int LEN_W = 8,
  parameter int OP_W  = dot_seq_pkg::OP_W,
  parameter int ACC_W = dot_seq_pkg::ACC_W
) (
  input  logic            clk,
  input  logic            aclr,
  dot_seq_feeder_if.slave bus
);
  import dot_seq_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_cnt;
  logic             r_res_valid;
  logic [ACC_W-1:0] r_res_data;
  logic             w_start_ok;
  logic             w_beat;
  logic             w_last;

  assign w_start_ok   = bus.start && (bus.vec_len != '0);
  assign bus.in_ready = (r_state == ACCUM);
  assign bus.busy     = (r_state != IDLE);
  assign w_beat       = bus.in_ready && bus.in_valid;
  assign w_last       = (r_cnt == LEN_W'(1));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next = ACCUM;
      ACCUM:   if (w_beat && w_last) w_next = DRAIN1;
      DRAIN1:  w_next = DRAIN2;
      DRAIN2:  w_next = HOLD;
      HOLD:    if (bus.res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_start_ok) begin
      r_cnt <= bus.vec_len;
    end else if (w_beat) begin
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

  // DRAIN2 samples the MAC one edge after it absorbed the final beat.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (r_state == DRAIN2) begin
      r_res_valid <= 1'b1;
      r_res_data  <= bus.mac_result;
    end else if (r_state == HOLD && bus.res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;

  dot_seq_opreg #(.OP_W(OP_W)) u_opreg (
    .clk     (clk),
    .aclr    (aclr),
    .i_beat  (w_beat),
    .i_last  (w_last),
    .i_a     (bus.in_a),
    .i_b     (bus.in_b),
    .o_dataa (bus.mac_dataa),
    .o_datab (bus.mac_datab),
    .o_clken (bus.mac_clken),
    .o_sload (bus.mac_sload)
  );

`ifdef DOT_SEQ_OVF_EN
  localparam int SH_W = shadow_w(ACC_W, LEN_W);

  logic [2*OP_W-1:0] w_prod;
  logic [SH_W-1:0]   r_shadow;
  logic              r_res_ovf;
  logic              w_ovf;

  // Truncated product of sign-extended operands is the exact signed product.
  assign w_prod = {{OP_W{bus.in_a[OP_W-1]}}, bus.in_a} *
                  {{OP_W{bus.in_b[OP_W-1]}}, bus.in_b};
  // Fits in ACC_W signed iff all bits from the ACC_W sign bit upward agree.
  assign w_ovf  = ~((&r_shadow[SH_W-1:ACC_W-1]) | ~(|r_shadow[SH_W-1:ACC_W-1]));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_shadow  <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      if (r_state == IDLE && w_start_ok) begin
        r_shadow <= '0;
      end else if (w_beat) begin
        r_shadow <= r_shadow + {{(SH_W-2*OP_W){w_prod[2*OP_W-1]}}, w_prod};
      end
      if (r_state == DRAIN2) r_res_ovf <= w_ovf;
    end
  end

  assign bus.res_ovf = r_res_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dot_seq_feeder.sv
// ============================================================================
// tb_dot_seq_feeder : randomized scoreboard bench with a behavioural MAC
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dot_seq_feeder;

  localparam int LEN_W = 8;
  localparam int OP_W  = 8;
  localparam int ACC_W = 18;

  typedef struct {
    logic [ACC_W-1:0] data;
    bit               ovf;
  } exp_t;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  dot_seq_feeder_if #(.LEN_W(LEN_W), .OP_W(OP_W), .ACC_W(ACC_W)) bus ();

  dot_seq_feeder #(.LEN_W(LEN_W), .OP_W(OP_W), .ACC_W(ACC_W)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (bus.slave)
  );

  // Behavioural MAC: sload on a beat clears the sum ahead of the next beat.
  logic [ACC_W-1:0] mac_acc;
  logic             mac_pend;
  int               mac_prod;
  assign mac_prod       = $signed(bus.mac_dataa) * $signed(bus.mac_datab);
  assign bus.mac_result = mac_acc;

  always @(posedge clk or posedge aclr) begin
    if (aclr) begin
      mac_acc  <= '0;
      mac_pend <= 1'b0;
    end else if (bus.mac_clken) begin
      mac_acc  <= (mac_pend ? '0 : mac_acc) + mac_prod[ACC_W-1:0];
      mac_pend <= bus.mac_sload;
    end
  end

  int   tests  = 0;
  int   fails  = 0;
  int   hs_cnt = 0;
  exp_t exp_q[$];
  int   va[256];
  int   vb[256];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: every handshake pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got %0d, expected no result", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", bus.res_data, e.data);
`ifdef DOT_SEQ_OVF_EN
          chk("res_ovf", bus.res_ovf, e.ovf);
`endif
        end
      end
    end
  end

  // Reference: plain signed dot product, wrapped to ACC_W bits.
  function automatic exp_t ref_dot(input int n);
    longint s;
    exp_t   e;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
    e.data = s[ACC_W-1:0];
    e.ovf  = (s > 131071) || (s < -131072);
    return e;
  endfunction

  // mode: 0 back-to-back, 1 alternate valid, 2 random valid.
  task automatic send_vec(input int n, input int mode, input int hold,
                          input bit poke_start, input int abort_after);
    exp_t             e;
    int               idx, budget, cyc, hs0;
    bit               tog, v, beat, pb, pl, poked;
    logic [OP_W-1:0]  pa, pbv;

    e = ref_dot(n);
    if (abort_after < 0) exp_q.push_back(e);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.vec_len = LEN_W'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);

    idx = 0; budget = 0; tog = 0; pb = 0; pl = 0; poked = 0; pa = '0; pbv = '0;
    while (idx < n) begin
      chk("mac_clken", bus.mac_clken, pb);
      chk("mac_sload", bus.mac_sload, pl);
      if (pb) begin
        chk("mac_dataa", bus.mac_dataa, pa);
        chk("mac_datab", bus.mac_datab, pbv);
      end
      if (abort_after >= 0 && idx == abort_after) begin
        aclr         = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_in_ready", bus.in_ready, 0);
        chk("abort_clken", bus.mac_clken, 0);
        chk("abort_dataa", bus.mac_dataa, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        @(negedge clk);
        aclr = 1'b0;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_a     = v ? OP_W'(va[idx]) : OP_W'($urandom);
      bus.in_b     = v ? OP_W'(vb[idx]) : OP_W'($urandom);
      if (poke_start && idx == 1 && !poked) begin
        bus.start   = 1'b1;
        bus.vec_len = 8'd200;
        poked       = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      chk("in_ready_accum", bus.in_ready, 1);
      beat = v && bus.in_ready;
      pb   = beat;
      pl   = beat && (idx == n - 1);
      pa   = bus.in_a;
      pbv  = bus.in_b;
      if (beat) idx++;
      @(negedge clk);
      budget++;
      if (budget > 4 * n + 20) begin
        tests++;
        fails++;
        $display("FAIL beat_timeout: got %0d beats, expected %0d", idx, n);
        break;
      end
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    chk("final_clken", bus.mac_clken, pb);
    chk("final_sload", bus.mac_sload, pl);
    chk("final_dataa", bus.mac_dataa, pa);

    // Two further edges: MAC absorbs the final beat, then DRAIN2 captures.
    cyc = 0;
    while (!bus.res_valid && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("res_latency", cyc, 2);
    chk("drain_clken", bus.mac_clken, 0);

    hs0 = hs_cnt;
    repeat (hold) begin
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", bus.res_data, e.data);
      chk("hold_busy", bus.busy, 1);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("handshake_once", hs_cnt - hs0, 1);
    chk("res_valid_clear", bus.res_valid, 0);
    chk("idle_after_result", bus.busy, 0);
  endtask

  initial begin
    aclr          = 1'b1;
    bus.start     = 1'b0;
    bus.vec_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_clken", bus.mac_clken, 0);
    chk("rst_sload", bus.mac_sload, 0);
    chk("rst_dataa", bus.mac_dataa, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    aclr = 1'b0;

    // Basic vector: 12 - 10 - 7 = -5
    va[0] = 3;  vb[0] = 4;
    va[1] = -2; vb[1] = 5;
    va[2] = 7;  vb[2] = -1;
    send_vec(3, 0, 0, 0, -1);

    // Back-to-back: 1 + 16384 proves the clear between vectors
    va[0] = 1;    vb[0] = 1;
    va[1] = -128; vb[1] = -128;
    send_vec(2, 0, 0, 0, -1);

    // Bubbles and backpressure: 4 * 6 = 24
    for (int i = 0; i < 4; i++) begin va[i] = 2; vb[i] = 3; end
    send_vec(4, 1, 5, 0, -1);

    // Zero-length start is ignored
    @(negedge clk);
    bus.start   = 1'b1;
    bus.vec_len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero_len_busy", bus.busy, 0);
    chk("zero_len_ready", bus.in_ready, 0);

    // Start during ACCUM is ignored
    for (int i = 0; i < 4; i++) begin
      va[i] = $urandom_range(0, 255) - 128;
      vb[i] = $urandom_range(0, 255) - 128;
    end
    send_vec(4, 0, 1, 1, -1);

    // Abort after 2 of 5 beats, then 5 * 6 = 30
    for (int i = 0; i < 5; i++) begin va[i] = 100; vb[i] = 100; end
    send_vec(5, 0, 0, 0, 2);
    va[0] = 5; vb[0] = 6;
    send_vec(1, 0, 0, 0, -1);

    // Randomized vectors
    for (int t = 0; t < 10; t++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        va[i] = $urandom_range(0, 255) - 128;
        vb[i] = $urandom_range(0, 255) - 128;
      end
      send_vec(n, $urandom_range(0, 2), $urandom_range(0, 3), 0, -1);
    end

`ifdef DOT_SEQ_OVF_EN
    // 8 * 16384 wraps to -131072 with overflow; 7 * 16384 fits
    for (int i = 0; i < 8; i++) begin va[i] = -128; vb[i] = -128; end
    send_vec(8, 0, 0, 0, -1);
    send_vec(7, 2, 2, 0, -1);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
